// File: rtl/flag_pkg.sv
// Shared flag definitions for the ALU, branch unit and flag unit.
// Also defines the stack operation code that passes from the flag register to its shadow stack.
package flag_pkg;
  localparam int NFLAGS_DEF = 3;
  localparam int FLAG_Z     = 2;
  localparam int FLAG_V     = 1;
  localparam int FLAG_N     = 0;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2,
    OP_SWAP = 2'd3
  } stk_op_t;
endpackage

// File: rtl/flag_unit_if.sv
// Flag unit port bundle: write/save/restore controls in, flags and stack status out.
// Purely combinational wiring; there is no handshake and no backpressure.
interface flag_unit_if import flag_pkg::*; #(
  parameter int NFLAGS = NFLAGS_DEF,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] wen;
  logic [NFLAGS-1:0] flags_in;
  logic              save;
  logic              restore;
  logic              err_clr;
  logic [NFLAGS-1:0] flags_out;
  logic [NFLAGS-1:0] flags_fwd;
  logic [CW-1:0]     depth_cnt;
  logic              full;
  logic              empty;
  logic              ovf_err;
  logic              unf_err;

  modport master (
    output wen, flags_in, save, restore, err_clr,
    input  flags_out, flags_fwd, depth_cnt, full, empty, ovf_err, unf_err
  );

  modport slave (
    input  wen, flags_in, save, restore, err_clr,
    output flags_out, flags_fwd, depth_cnt, full, empty, ovf_err, unf_err
  );
endinterface

// File: rtl/flag_stack.sv
// LIFO shadow stack with push/pop/swap; one-cycle update, top and status are combinational from state.
// No backpressure: the caller must not push when full or pop/swap when empty.
module flag_stack import flag_pkg::*; #(
  parameter int  W     = NFLAGS_DEF,
  parameter int  DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  stk_op_t       op,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  top,
  output logic [CW-1:0] depth_cnt,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (op)
        OP_PUSH: depth_cnt <= depth_cnt + CW'(1);
        OP_POP:  depth_cnt <= depth_cnt - CW'(1);
        default: depth_cnt <= depth_cnt;
      endcase
      // Push writes the slot just above the top; swap overwrites the top itself.
      for (int i = 0; i < DEPTH; i++) begin
        if ((op == OP_PUSH && depth_cnt == CW'(i)) ||
            (op == OP_SWAP && depth_cnt == CW'(i + 1)))
          mem[i] <= din;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_cnt == CW'(i + 1)) top = mem[i];
    end
  end

  assign full  = (depth_cnt == CW'(DEPTH));
  assign empty = (depth_cnt == '0);
endmodule

// File: rtl/flag_unit.sv
// Condition-flag register with per-bit enables, same-cycle forwarding and a save/restore shadow stack.
// Flags update one cycle after write/restore; flags_fwd is combinational. No backpressure; misuse sets sticky errors.
module flag_unit import flag_pkg::*; #(
  parameter int NFLAGS = NFLAGS_DEF,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input logic        clk,
  input logic        rst,
  flag_unit_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [NFLAGS-1:0] flags;
  logic [NFLAGS-1:0] written;
  logic [NFLAGS-1:0] top;
  logic [CW-1:0]     depth_cnt;
  logic              full;
  logic              empty;
  logic              ovf_err;
  logic              unf_err;
  logic              accept_pop;
  stk_op_t           op;

  // A restore that finds an entry takes priority over any flag write.
  assign accept_pop = bus.restore && !empty;
  assign written    = (flags & ~bus.wen) | (bus.flags_in & bus.wen);

  always_comb begin
    op = OP_NONE;
    if (accept_pop)
      op = bus.save ? OP_SWAP : OP_POP;
    else if (bus.save && !full)
      op = OP_PUSH;
  end

  flag_stack #(.W(NFLAGS), .DEPTH(DEPTH)) u_stack (
    .clk       (clk),
    .rst       (rst),
    .op        (op),
    .din       (flags),
    .top       (top),
    .depth_cnt (depth_cnt),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags   <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      flags   <= accept_pop ? top : written;
      // Save while full with a pending pop is a swap, not an overflow.
      ovf_err <= (bus.save && !bus.restore && full) || (ovf_err && !bus.err_clr);
      unf_err <= (bus.restore && empty) || (unf_err && !bus.err_clr);
    end
  end

  always_comb begin
    bus.flags_fwd = flags;
    if (BYPASS != 0 && !accept_pop) bus.flags_fwd = written;
  end

  assign bus.flags_out = flags;
  assign bus.depth_cnt = depth_cnt;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.ovf_err   = ovf_err;
  assign bus.unf_err   = unf_err;
endmodule

// File: tb/tb_flag_unit.sv
// Directed bench for flag_unit: queue-based reference model checked every negedge, plus literal spot checks.
module tb_flag_unit;
  import flag_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic chk_en = 1'b0;
  int   total = 0;
  int   bad = 0;

  flag_unit_if #(.NFLAGS(3), .DEPTH(DEPTH)) if0 ();
  flag_unit_if #(.NFLAGS(3), .DEPTH(DEPTH)) if1 ();

  flag_unit #(.NFLAGS(3), .DEPTH(DEPTH), .BYPASS(1)) dut  (.clk(clk), .rst(rst), .bus(if0));
  flag_unit #(.NFLAGS(3), .DEPTH(DEPTH), .BYPASS(0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  assign if1.wen      = if0.wen;
  assign if1.flags_in = if0.flags_in;
  assign if1.save     = if0.save;
  assign if1.restore  = if0.restore;
  assign if1.err_clr  = if0.err_clr;

  always #5 clk = ~clk;

  // Reference model: flags, a queue as the stack, sticky error bits.
  logic [2:0] m_flags = '0;
  logic [2:0] m_stk[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic [2:0] m_next;
  logic       m_ov, m_un;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_flags = '0;
      m_stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_next = m_flags;
      for (int i = 0; i < 3; i++) if (if0.wen[i]) m_next[i] = if0.flags_in[i];
      m_ov = 1'b0;
      m_un = 1'b0;
      if (if0.restore && m_stk.size() > 0) begin
        m_next = m_stk[m_stk.size()-1];
        if (if0.save) m_stk[m_stk.size()-1] = m_flags;
        else void'(m_stk.pop_back());
      end else begin
        if (if0.restore) m_un = 1'b1;
        if (if0.save) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(m_flags);
          else m_ov = 1'b1;
        end
      end
      m_flags = m_next;
      m_ovf = m_ov || (m_ovf && !if0.err_clr);
      m_unf = m_un || (m_unf && !if0.err_clr);
    end
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [2:0] e_fwd;
  always @(negedge clk) begin
    if (chk_en) begin
      if (if0.restore && m_stk.size() > 0) e_fwd = m_flags;
      else e_fwd = (m_flags & ~if0.wen) | (if0.flags_in & if0.wen);
      cmp("m.flags_out", 8'(if0.flags_out), 8'(m_flags));
      cmp("m.flags_fwd", 8'(if0.flags_fwd), 8'(e_fwd));
      cmp("m.depth_cnt", 8'(if0.depth_cnt), 8'(m_stk.size()));
      cmp("m.full",      8'(if0.full),      8'(m_stk.size() == DEPTH));
      cmp("m.empty",     8'(if0.empty),     8'(m_stk.size() == 0));
      cmp("m.ovf_err",   8'(if0.ovf_err),   8'(m_ovf));
      cmp("m.unf_err",   8'(if0.unf_err),   8'(m_unf));
      cmp("m.nobyp_fwd", 8'(if1.flags_fwd), 8'(m_flags));
      cmp("m.nobyp_out", 8'(if1.flags_out), 8'(m_flags));
    end
  end

  task automatic drive(input logic [2:0] w, input logic [2:0] f, input logic s, input logic r, input logic c);
    if0.wen      = w;
    if0.flags_in = f;
    if0.save     = s;
    if0.restore  = r;
    if0.err_clr  = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    #12;
    cmp("rst.flags_out", 8'(if0.flags_out), 8'h0);
    cmp("rst.depth_cnt", 8'(if0.depth_cnt), 8'h0);
    cmp("rst.empty",     8'(if0.empty),     8'h1);
    cmp("rst.full",      8'(if0.full),      8'h0);
    cmp("rst.errs",      8'({if0.ovf_err, if0.unf_err}), 8'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;

    // Writes and same-cycle forwarding
    drive(3'b111, 3'b101, 1'b0, 1'b0, 1'b0);
    #1 cmp("t1.fwd", 8'(if0.flags_fwd), 8'h5);
    tick();
    cmp("t1.out", 8'(if0.flags_out), 8'h5);
    drive(3'b010, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    cmp("t1.wen010", 8'(if0.flags_out), 8'h5);
    drive(3'b001, 3'b000, 1'b0, 1'b0, 1'b0);
    tick();
    cmp("t1.wen001", 8'(if0.flags_out), 8'h4);

    // Save with concurrent write, then restore
    drive(3'b111, 3'b101, 1'b0, 1'b0, 1'b0);
    tick();
    drive(3'b111, 3'b010, 1'b1, 1'b0, 1'b0);
    tick();
    cmp("t2.out", 8'(if0.flags_out), 8'h2);
    cmp("t2.depth", 8'(if0.depth_cnt), 8'h1);
    drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0);
    tick();
    cmp("t2.restore", 8'(if0.flags_out), 8'h5);
    cmp("t2.empty", 8'(if0.empty), 8'h1);

    // Fill, overflow, LIFO drain: pushes 101,001,010,011
    drive(3'b111, 3'b001, 1'b1, 1'b0, 1'b0); tick();
    drive(3'b111, 3'b010, 1'b1, 1'b0, 1'b0); tick();
    drive(3'b111, 3'b011, 1'b1, 1'b0, 1'b0); tick();
    drive(3'b111, 3'b110, 1'b1, 1'b0, 1'b0); tick();
    cmp("t3.full", 8'(if0.full), 8'h1);
    drive(3'b111, 3'b111, 1'b1, 1'b0, 1'b0); tick();
    cmp("t3.ovf", 8'(if0.ovf_err), 8'h1);
    cmp("t3.depth", 8'(if0.depth_cnt), 8'h4);
    cmp("t3.ovf_wen", 8'(if0.flags_out), 8'h7);
    drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    cmp("t3.pop0", 8'(if0.flags_out), 8'h3);
    tick();
    cmp("t3.pop1", 8'(if0.flags_out), 8'h2);
    tick();
    cmp("t3.pop2", 8'(if0.flags_out), 8'h1);
    drive(3'b111, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    cmp("t3.pop3_wins", 8'(if0.flags_out), 8'h5);

    // Underflow with write, error clearing
    drive(3'b111, 3'b000, 1'b0, 1'b0, 1'b0); tick();
    drive(3'b001, 3'b001, 1'b0, 1'b1, 1'b0); tick();
    cmp("t4.unf", 8'(if0.unf_err), 8'h1);
    cmp("t4.out", 8'(if0.flags_out), 8'h1);
    drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b1); tick();
    cmp("t4.clr", 8'({if0.ovf_err, if0.unf_err}), 8'h0);
    drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b1); tick();
    cmp("t4.clr_set", 8'(if0.unf_err), 8'h1);

    // Swap: push 001, push 011, flags 110
    drive(3'b111, 3'b011, 1'b1, 1'b0, 1'b1); tick();
    drive(3'b111, 3'b110, 1'b1, 1'b0, 1'b0); tick();
    drive(3'b111, 3'b000, 1'b1, 1'b1, 1'b0);
    #1 cmp("t5.fwd_hold", 8'(if0.flags_fwd), 8'h6);
    tick();
    cmp("t5.swap_out", 8'(if0.flags_out), 8'h3);
    cmp("t5.swap_depth", 8'(if0.depth_cnt), 8'h2);
    drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    cmp("t5.new_top", 8'(if0.flags_out), 8'h6);
    tick();
    cmp("t5.bottom", 8'(if0.flags_out), 8'h1);
    drive(3'b111, 3'b010, 1'b1, 1'b1, 1'b0); tick();
    cmp("t5.sr_empty_unf", 8'(if0.unf_err), 8'h1);
    cmp("t5.sr_empty_out", 8'(if0.flags_out), 8'h2);
    cmp("t5.sr_empty_depth", 8'(if0.depth_cnt), 8'h1);

    // Async reset with three entries, then the non-bypass build
    drive(3'b000, 3'b000, 1'b1, 1'b0, 1'b0); tick(); tick();
    cmp("t6.depth3", 8'(if0.depth_cnt), 8'h3);
    drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    cmp("t6.out",   8'(if0.flags_out), 8'h0);
    cmp("t6.fwd",   8'(if0.flags_fwd), 8'h0);
    cmp("t6.depth", 8'(if0.depth_cnt), 8'h0);
    cmp("t6.empty", 8'(if0.empty), 8'h1);
    cmp("t6.errs",  8'({if0.ovf_err, if0.unf_err}), 8'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(3'b111, 3'b101, 1'b0, 1'b0, 1'b0);
    #1;
    cmp("t6.nobyp_fwd", 8'(if1.flags_fwd), 8'h0);
    cmp("t6.byp_fwd", 8'(if0.flags_fwd), 8'h5);
    tick();
    cmp("t6.nobyp_out", 8'(if1.flags_out), 8'h5);
    drive(3'b000, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    cmp("t6.post_rst_unf", 8'(if0.unf_err), 8'h1);
    drive(3'b000, 3'b000, 1'b0, 1'b0, 1'b0); tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
